mux_sel_arbiter: RTL and testbench
==================================

// Module: mux_sel_arbiter
//
// PURPOSE
//   Upstream control stage for the 2:1 MUX. It arbitrates between two
//   valid/ready input streams (A, B) and drives the MUX select line.
//   It also delivers the accepted beats through a one-entry registered
//   output stage with valid/ready.
//   Round-robin on ties, with a bounded burst length per grant so neither
//   source starves.
//   sel convention: sel=0 selects A, sel=1 selects B (same as MUX).
//
// PARAMETERS
//   WIDTH  1  data width of each stream (1 matches the bit-level MUX)
//   BURST  4  max consecutive beats per grant before yielding to the other
//             source (>=1)
//
// PORTS
//   clk        in   1      single clock, all logic on posedge
//   rst        in   1      synchronous, active-high reset
//   a_valid    in   1      stream A beat available
//   a_data     in   WIDTH  stream A data
//   a_ready    out  1      stream A beat accepted this cycle if a_valid
//   b_valid    in   1      stream B beat available
//   b_data     in   WIDTH  stream B data
//   b_ready    out  1      stream B beat accepted this cycle if b_valid
//   sel        out  1      registered MUX select: 0=A, 1=B
//   out_valid  out  1      output beat valid (registered)
//   out_data   out  WIDTH  output beat data (registered)
//   out_src    out  1      source of the current out_data: 0=A, 1=B
//   out_ready  in   1      downstream accepts the output beat
//
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, sel=0, out_valid=0, out_data=0,
//     out_src=0, beat_cnt=0, last_grant=B (so A wins the first tie).
//     Reset mid-burst drops any held output beat.
//   Definitions:
//     space    = !out_valid | out_ready
//     a_ready  = (state==GNT_A) & space
//     b_ready  = (state==GNT_B) & space   (combinational, never both high)
//     acc_x    = x_valid & x_ready
//   FSM states: IDLE, GNT_A, GNT_B.
//   IDLE:
//     - both valid: grant the source != last_grant.
//     - one valid: grant it.
//     - none valid: stay.
//     - On a grant: sel<=granted source, beat_cnt<=0.
//     - No beat is accepted in IDLE.
//   GNT_x:
//     - acc_x increments beat_cnt.
//     - x_valid=0 -> IDLE, last_grant<=x.
//     - acc_x with beat_cnt==BURST-1 and the other source valid ->
//       GNT_other directly, sel flips, beat_cnt<=0, last_grant<=x.
//     - acc_x with beat_cnt==BURST-1 and the other source idle ->
//       stay in GNT_x, beat_cnt<=0.
//     - Otherwise stay.
//   sel changes only on a grant transition. It holds its value in IDLE and
//     for the whole grant.
//   Output register, updated when space=1:
//     out_valid<=acc_a|acc_b; out_data<=accepted data; out_src<=sel.
//     When space=0 it holds all output values.
//   Latency:
//     - x_valid rising in IDLE at cycle 0: grant at cycle 1, x_ready=1 at
//       cycle 1, out_valid=1 at cycle 2.
//     - Steady state: 1 beat/cycle while out_ready=1.
//   Backpressure: out_ready=0 with out_valid=1 forces both readys low. No
//     beat is lost or duplicated. out_data stays stable while
//     out_valid & !out_ready.
//   beat_cnt width: clog2(BURST) bits, min 1. It never exceeds BURST-1.
//
// TESTING
//   1 Reset: hold rst 2 cycles with a_valid=b_valid=1 -> sel=0,
//     out_valid=0, a_ready=b_ready=0.
//   2 Single stream: a_valid=1, a_data=1 from cycle 0, out_ready=1 ->
//     a_ready=1 at cycle 1, out_valid=1, out_data=1, out_src=0 at cycle 2,
//     sel stays 0.
//   3 Tie, BURST=4: both valid continuously, out_ready=1 ->
//     out_src sequence A,A,A,A,B,B,B,B,A...; sel flips every 4 beats.
//   4 Backpressure: out_ready=0 for 3 cycles mid-burst -> out_data and
//     out_valid held, a_ready=0. On release, beats resume in order with
//     none lost or duplicated.
//   5 Source drop: B granted, b_valid deasserts while a_valid=1 -> IDLE
//     for 1 cycle, then GNT_A, sel=0. last_grant=B gives A the next tie.
//   6 Random: random valids, data and out_ready for 2000 cycles.
//     Scoreboard per source checks order and completeness. Checks that
//     a_ready & b_ready is never 1 and that no source waits more than
//     BURST+2 beats while valid.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// Two-stream round-robin arbiter that drives the 2:1 MUX select and forwards
// accepted beats through a one-entry registered output stage.
module mux_sel_arbiter #(
  parameter int WIDTH = 1,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_A = 2'd1,
    S_GNT_B = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_sel;
  logic             w_sel_next;
  logic [CW-1:0]    r_beat_cnt;
  logic [CW-1:0]    w_beat_cnt_next;
  logic             r_last_grant;
  logic             w_last_grant_next;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_src;
  logic             w_space;
  logic             w_acc_a;
  logic             w_acc_b;

  // State register plus the output holding stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_beat_cnt   <= '0;
      r_last_grant <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_src    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_sel        <= w_sel_next;
      r_beat_cnt   <= w_beat_cnt_next;
      r_last_grant <= w_last_grant_next;
      if (w_space) begin
        r_out_valid <= w_acc_a | w_acc_b;
        r_out_src   <= r_sel;
        if (w_acc_a) begin
          r_out_data <= a_data;
        end else if (w_acc_b) begin
          r_out_data <= b_data;
        end
      end
    end
  end

  // Next-state logic: a grant ends when its source drops or its burst is
  // used up while the other side is waiting.
  always_comb begin
    w_state_next      = r_state;
    w_sel_next        = r_sel;
    w_beat_cnt_next   = r_beat_cnt;
    w_last_grant_next = r_last_grant;
    case (r_state)
      S_IDLE: begin
        if (a_valid && (!b_valid || r_last_grant)) begin
          w_state_next    = S_GNT_A;
          w_sel_next      = 1'b0;
          w_beat_cnt_next = '0;
        end else if (b_valid) begin
          w_state_next    = S_GNT_B;
          w_sel_next      = 1'b1;
          w_beat_cnt_next = '0;
        end
      end
      S_GNT_A: begin
        if (!a_valid) begin
          w_state_next      = S_IDLE;
          w_last_grant_next = 1'b0;
        end else if (w_acc_a) begin
          if (r_beat_cnt == CNT_LAST) begin
            w_beat_cnt_next = '0;
            if (b_valid) begin
              w_state_next      = S_GNT_B;
              w_sel_next        = 1'b1;
              w_last_grant_next = 1'b0;
            end
          end else begin
            w_beat_cnt_next = r_beat_cnt + 1'b1;
          end
        end
      end
      S_GNT_B: begin
        if (!b_valid) begin
          w_state_next      = S_IDLE;
          w_last_grant_next = 1'b1;
        end else if (w_acc_b) begin
          if (r_beat_cnt == CNT_LAST) begin
            w_beat_cnt_next = '0;
            if (a_valid) begin
              w_state_next      = S_GNT_A;
              w_sel_next        = 1'b0;
              w_last_grant_next = 1'b1;
            end
          end else begin
            w_beat_cnt_next = r_beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output logic: readys follow the grant, gated by room in the output stage
  always_comb begin
    w_space = !r_out_valid || out_ready;
    a_ready = (r_state == S_GNT_A) && w_space;
    b_ready = (r_state == S_GNT_B) && w_space;
    w_acc_a = a_valid && a_ready;
    w_acc_b = b_valid && b_ready;
  end

  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench: accepted beats are queued as {source, data} and a
// negedge monitor checks each delivered beat plus arbitration invariants.
module tb_mux_sel_arbiter;
  localparam int WIDTH = 1;
  localparam int BURST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;

  mux_sel_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .sel(sel),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  typedef struct {
    logic             src;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: everything sampled mid-cycle, commits happen at the next posedge
  beat_t            m_e;
  logic             m_hold_v = 1'b0;
  logic [WIDTH-1:0] m_hold_d;
  logic             m_hold_s;
  logic             m_acc_a;
  logic             m_acc_b;
  int               m_wait_a = 0;
  int               m_wait_b = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_hold_v = 1'b0;
        m_wait_a = 0;
        m_wait_b = 0;
      end else begin
        chk("both_ready", a_ready & b_ready, 0);
        if (a_ready) chk("sel_when_a_ready", sel, 0);
        if (b_ready) chk("sel_when_b_ready", sel, 1);
        if (m_hold_v) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, m_hold_d);
          chk("hold_src", out_src, m_hold_s);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", out_valid, 0);
          end else begin
            m_e = exp_q.pop_front();
            chk("out_src", out_src, m_e.src);
            chk("out_data", out_data, m_e.data);
          end
        end
        m_hold_v = out_valid && !out_ready;
        m_hold_d = out_data;
        m_hold_s = out_src;
        m_acc_a = a_valid && a_ready;
        m_acc_b = b_valid && b_ready;
        if (m_acc_a) exp_q.push_back('{src: 1'b0, data: a_data});
        if (m_acc_b) exp_q.push_back('{src: 1'b1, data: b_data});
        // Starvation bound: beats granted to the other side while this one waits
        if (a_valid && !m_acc_a && m_acc_b) begin
          m_wait_a++;
          chk("wait_a_bound", m_wait_a > BURST + 2, 0);
        end else if (!a_valid || m_acc_a) begin
          m_wait_a = 0;
        end
        if (b_valid && !m_acc_b && m_acc_a) begin
          m_wait_b++;
          chk("wait_b_bound", m_wait_b > BURST + 2, 0);
        end else if (!b_valid || m_acc_b) begin
          m_wait_b = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Driver and directed checks
  int               k;
  logic [WIDTH-1:0] hd;
  logic             pa;
  logic             pb;

  initial begin
    rst       = 1'b1;
    a_valid   = 1'b1;
    b_valid   = 1'b1;
    a_data    = '0;
    b_data    = '0;
    out_ready = 1'b1;

    // Reset held two cycles with both sources requesting
    tick();
    tick();
    @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    do_reset();

    // Single stream latency
    a_valid = 1'b1;
    a_data  = WIDTH'(1);
    @(negedge clk);
    chk("single_c0_a_ready", a_ready, 0);
    tick();
    @(negedge clk);
    chk("single_c1_a_ready", a_ready, 1);
    chk("single_c1_sel", sel, 0);
    tick();
    @(negedge clk);
    chk("single_c2_out_valid", out_valid, 1);
    chk("single_c2_out_data", out_data, 1);
    chk("single_c2_out_src", out_src, 0);
    chk("single_c2_sel", sel, 0);
    tick();
    a_valid = 1'b0;
    repeat (4) tick();

    // Tie: bursts of BURST beats alternating, A first after reset
    do_reset();
    a_valid = 1'b1;
    b_valid = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 12; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        chk("tie_src_order", out_src, (k / BURST) % 2);
        k++;
      end
      tick();
      a_data = WIDTH'($urandom);
      b_data = WIDTH'($urandom);
    end
    chk("tie_beat_count", k, 12);

    // Backpressure mid-burst
    do_reset();
    a_valid = 1'b1;
    repeat (3) begin
      a_data = WIDTH'($urandom);
      tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) hd = out_data;
      else chk("bp_data_stable", out_data, hd);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_a_ready", a_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    repeat (6) begin
      a_data = WIDTH'($urandom);
      tick();
    end
    a_valid = 1'b0;
    repeat (4) tick();

    // Source drop: B loses its grant, A then wins the following tie
    do_reset();
    b_valid = 1'b1;
    tick();
    @(negedge clk);
    chk("drop_b_ready", b_ready, 1);
    chk("drop_sel_b", sel, 1);
    tick();
    b_valid = 1'b0;
    a_valid = 1'b1;
    tick();
    b_valid = 1'b1;
    @(negedge clk);
    chk("drop_idle_a_ready", a_ready, 0);
    chk("drop_idle_b_ready", b_ready, 0);
    tick();
    @(negedge clk);
    chk("drop_gnt_a_ready", a_ready, 1);
    chk("drop_gnt_b_ready", b_ready, 0);
    chk("drop_gnt_sel", sel, 0);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (4) tick();

    // Random traffic with random backpressure and one mid-run reset
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      pa = a_valid && a_ready;
      pb = b_valid && b_ready;
      tick();
      if (c == 1000) begin
        do_reset();
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        pa = 1'b0;
        pb = 1'b0;
        tick();
      end
      if (!a_valid || pa) begin
        a_valid = ($urandom_range(0, 9) < 7);
        a_data  = WIDTH'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        a_valid = 1'b0;
      end
      if (!b_valid || pb) begin
        b_valid = ($urandom_range(0, 9) < 7);
        b_data  = WIDTH'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        b_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain and confirm nothing was lost
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_out_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
